// File: rtl/mux_nx1_pipe_pkg.sv
// Shared types and constants for the FP operand-select mux and its skid buffer.
// Occupancy encoding doubles as the count output value.
package mux_nx1_pipe_pkg;

  localparam int FP_MANT_W = 24;
  localparam int FP_EXP_W  = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/mux_nx1_pipe_skid.sv
// Two-entry skid buffer: registered main stage plus one skid slot behind valid/ready.
// in_ready depends only on registered occupancy, never on out_ready.
//
// state     | meaning
// OCC_EMPTY | nothing held, out_valid=0
// OCC_ONE   | main holds the oldest word
// OCC_FULL  | main and skid hold words, in_ready=0
module skid_buffer
  import mux_nx1_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   count
);

  occ_e         state_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OCC_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_valid) begin
            main_q  <= in_data;
            state_q <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          case ({in_valid, out_ready})
            2'b11: main_q <= in_data;
            2'b10: begin
              skid_q  <= in_data;
              state_q <= OCC_FULL;
            end
            2'b01: state_q <= OCC_EMPTY;
            default: ;
          endcase
        end
        OCC_FULL: begin
          // Skid is always the younger entry, so it moves up into main.
          if (out_ready) begin
            main_q  <= skid_q;
            state_q <= OCC_ONE;
          end
        end
        default: state_q <= OCC_EMPTY;
      endcase
    end
  end

  assign in_ready  = (state_q != OCC_FULL);
  assign out_valid = (state_q != OCC_EMPTY);
  assign out_data  = main_q;
  assign count     = state_q;

endmodule

// File: rtl/mux_nx1_pipe.sv
// N-to-1 operand select for the FP datapath, registered through a 2-entry skid buffer.
// The select travels with the word; an out-of-range select yields zero and a sticky error.
module mux_nx1_pipe
  import mux_nx1_pipe_pkg::*;
#(
  parameter  int WIDTH = FP_MANT_W,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err,
  output logic [1:0]         count
);

  localparam logic [SEL_W:0] N_L = N[SEL_W:0];

  logic [WIDTH-1:0]       word;
  logic                   sel_oor;
  logic [WIDTH+SEL_W-1:0] pack_in;
  logic [WIDTH+SEL_W-1:0] pack_out;
  logic                   sel_err_q;
  logic                   sel_err_d;

  // Unmatched selects fall through to the zero default.
  always_comb begin
    word = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == i[SEL_W-1:0]) word = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign sel_oor = ({1'b0, sel} >= N_L);
  assign pack_in = {word, sel};

  skid_buffer #(.W(WIDTH + SEL_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_data   (pack_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (pack_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  assign out_data = pack_out[WIDTH+SEL_W-1:SEL_W];
  assign out_sel  = pack_out[SEL_W-1:0];

  assign sel_err_d = sel_err_q | (in_valid & in_ready & sel_oor);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_err_q <= 1'b0;
    else       sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: a power-of-two (N=4) and a non-power-of-two (N=3) instance.
module tb_mux_nx1_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [95:0] in4;
  logic [1:0]  sel4, os4, cnt4;
  logic        iv4, ir4, ov4, or4, se4;
  logic [23:0] od4;

  logic [71:0] in3;
  logic [1:0]  sel3, os3, cnt3;
  logic        iv3, ir3, ov3, or3, se3;
  logic [23:0] od3;

  mux_nx1_pipe #(.WIDTH(24), .N(4)) u4 (
    .clk(clk), .reset(reset), .in_data(in4), .sel(sel4), .in_valid(iv4), .in_ready(ir4),
    .out_data(od4), .out_sel(os4), .out_valid(ov4), .out_ready(or4), .sel_err(se4),
    .count(cnt4)
  );

  mux_nx1_pipe #(.WIDTH(24), .N(3)) u3 (
    .clk(clk), .reset(reset), .in_data(in3), .sel(sel3), .in_valid(iv3), .in_ready(ir3),
    .out_data(od3), .out_sel(os3), .out_valid(ov3), .out_ready(or3), .sel_err(se3),
    .count(cnt3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [23:0] exp_data;
  } vec_t;
  vec_t vecs[5];

  logic [25:0] q[$];
  logic [23:0] exp_word;

  initial begin
    vecs[0] = '{sel: 2'd2, exp_data: 24'd3};
    vecs[1] = '{sel: 2'd0, exp_data: 24'd1};
    vecs[2] = '{sel: 2'd1, exp_data: 24'd2};
    vecs[3] = '{sel: 2'd2, exp_data: 24'd3};
    vecs[4] = '{sel: 2'd3, exp_data: 24'd4};

    reset = 1'b1;
    in4 = {24'd4, 24'd3, 24'd2, 24'd1}; sel4 = 0; iv4 = 0; or4 = 0;
    in3 = {24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA}; sel3 = 0; iv3 = 0; or3 = 0;
    #1;
    check("rst_out_valid", ov4, 0);
    check("rst_out_data", od4, 0);
    check("rst_out_sel", os4, 0);
    check("rst_count", cnt4, 0);
    check("rst_in_ready", ir4, 1);
    check("rst_sel_err", se4, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step();

    // Single select, then back-to-back stream with out_ready high.
    or4 = 1;
    for (int i = 0; i < 5; i++) begin
      sel4 = vecs[i].sel; iv4 = 1;
      step();
      check("tbl_out_data", od4, vecs[i].exp_data);
      check("tbl_out_sel", os4, vecs[i].sel);
      check("tbl_out_valid", ov4, 1);
      check("tbl_in_ready", ir4, 1);
      check("tbl_count", cnt4, 1);
    end
    iv4 = 0;
    step();
    check("drain_out_valid", ov4, 0);
    check("drain_count", cnt4, 0);

    // Backpressure: fill both entries, hold, then drain in order.
    or4 = 0;
    iv4 = 1; sel4 = 0; step();
    sel4 = 1; step();
    iv4 = 0;
    check("bp_count_full", cnt4, 2);
    check("bp_in_ready", ir4, 0);
    check("bp_hold_data", od4, 1);
    sel4 = 3; iv4 = 1; step();
    iv4 = 0;
    check("bp_held_data", od4, 1);
    check("bp_held_sel", os4, 0);
    check("bp_still_full", cnt4, 2);
    or4 = 1; step();
    check("bp_second_data", od4, 2);
    check("bp_count_one", cnt4, 1);
    step();
    check("bp_count_zero", cnt4, 0);
    check("bp_valid_low", ov4, 0);

    // N=3: out-of-range select gives zero and a sticky error.
    or3 = 1; iv3 = 1; sel3 = 3; step();
    check("oor_data", od3, 0);
    check("oor_sel", os3, 3);
    check("oor_err", se3, 1);
    sel3 = 1; step();
    iv3 = 0;
    check("oor_next_data", od3, 24'hBBBBBB);
    check("oor_err_sticky", se3, 1);
    step();
    check("oor_err_idle", se3, 1);

    // Asynchronous reset while full.
    or4 = 0; iv4 = 1; sel4 = 2; step(); step();
    iv4 = 0;
    check("prerst_count", cnt4, 2);
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", ov4, 0);
    check("arst_count", cnt4, 0);
    check("arst_in_ready", ir4, 1);
    check("arst_out_data", od4, 0);
    check("arst_sel_err3", se3, 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Random traffic against a queue scoreboard.
    for (int c = 0; c < 10000; c++) begin
      iv4 = ($urandom_range(0, 3) != 0);
      or4 = ($urandom_range(0, 2) != 0);
      sel4 = 2'($urandom_range(0, 3));
      in4 = {$urandom, $urandom, $urandom};
      @(negedge clk);
      check("rnd_count", cnt4, q.size());
      check("rnd_in_ready", ir4, q.size() < 2);
      check("rnd_out_valid", ov4, q.size() > 0);
      if (q.size() > 0) begin
        check("rnd_out_data", od4, q[0][25:2]);
        check("rnd_out_sel", os4, q[0][1:0]);
      end
      if (q.size() > 0 && or4) void'(q.pop_front());
      if (iv4 && q.size() < 2 + ((ov4 && or4) ? 1 : 0) && ir4 === 1'b1) begin
        exp_word = 24'((in4 >> (int'(sel4) * 24)) & 96'hFFFFFF);
        q.push_back({exp_word, sel4});
      end else if (iv4 && ir4 !== 1'b1 && q.size() < 2 - ((ov4 && or4) ? 0 : 0)) begin
        // Model expected acceptance that the DUT refused; already counted by rnd_in_ready.
      end
      @(posedge clk);
      #1;
    end
    iv4 = 0; or4 = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (q.size() > 0) begin
        check("fin_out_data", od4, q[0][25:2]);
        void'(q.pop_front());
      end
    end
    @(negedge clk);
    check("fin_count", cnt4, 0);
    check("fin_queue_empty", q.size(), 0);
    check("fin_sel_err4", se4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
